// File: rtl/vdc_pll_supervisor.sv
// Sequences the VDC pixel-clock PLL reset and lock qualification and counts lock events.
// Lock is seen 2 cycles late, relock_req 1 cycle late. Outputs are registered. No backpressure.
module vdc_pll_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             vdc_reset,
  output logic             ready,
  output logic [CNT_W-1:0] lol_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAX_C = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic          relock_q;

  assign locked_s = sync_q[1];

  // pll_locked comes from the PLL output stage, unrelated to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b00;
      relock_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pll_locked};
      relock_q <= relock_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RST_PLL;
      timer         <= '0;
      pll_rst       <= 1'b1;
      vdc_reset     <= 1'b1;
      ready         <= 1'b0;
      lol_count     <= '0;
      timeout_count <= '0;
    end else begin
      timer <= timer + 1'b1;
      case (state)
        RST_PLL: begin
          if (timer == RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (relock_q) begin
            state   <= RST_PLL;
            timer   <= '0;
            pll_rst <= 1'b1;
          end else if (locked_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            state   <= RST_PLL;
            timer   <= '0;
            pll_rst <= 1'b1;
            if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
          end
        end
        STABLE: begin
          if (relock_q) begin
            state   <= RST_PLL;
            timer   <= '0;
            pll_rst <= 1'b1;
          end else if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == ST_LAST) begin
            state     <= RUN;
            timer     <= '0;
            ready     <= 1'b1;
            vdc_reset <= 1'b0;
          end
        end
        RUN: begin
          // timer is unused here; parking it at 0 keeps it from wrapping
          timer <= '0;
          if (!locked_s || relock_q) begin
            state     <= RST_PLL;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            vdc_reset <= 1'b1;
            if (!locked_s && (lol_count != '1)) lol_count <= lol_count + 1'b1;
          end
        end
        default: begin
          state     <= RST_PLL;
          timer     <= '0;
          pll_rst   <= 1'b1;
          ready     <= 1'b0;
          vdc_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdc_pll_supervisor.sv
// Bench for vdc_pll_supervisor: directed scenarios plus random lock/relock traffic
// compared every cycle against a timestamp-based reference model.
module tb_vdc_pll_supervisor;

  localparam int P    = 4;
  localparam int SC   = 8;
  localparam int TO   = 20;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic          vdc_reset;
  logic          ready;
  logic [CW-1:0] lol_count;
  logic [CW-1:0] timeout_count;

  always #10 clk = ~clk;

  vdc_pll_supervisor #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .vdc_reset    (vdc_reset),
    .ready        (ready),
    .lol_count    (lol_count),
    .timeout_count(timeout_count)
  );

  int tests = 0;
  int fails = 0;

  // n = rising edges since the last reset release; histories are indexed by edge
  int n;
  bit lk_h [0:8191];
  bit rq_h [0:8191];

  int m_ph;
  int m_entry;
  int m_lol;
  int m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph    = PH_RST;
    m_entry = 0;
    m_lol   = 0;
    m_to    = 0;
    n       = 0;
  endfunction

  function automatic void go(input int p);
    m_ph    = p;
    m_entry = n;
  endfunction

  // Lock as the FSM sees it at edge n was sampled at pin level two edges earlier;
  // a relock request one edge earlier.
  function automatic void model_step();
    bit ls;
    bit rq;
    int d;
    ls = (n >= 3) ? lk_h[n-2] : 1'b0;
    rq = (n >= 2) ? rq_h[n-1] : 1'b0;
    d  = n - m_entry;
    case (m_ph)
      PH_RST: if (d == P) go(PH_WAIT);
      PH_WAIT: begin
        if (rq) go(PH_RST);
        else if (ls) go(PH_STABLE);
        else if (d == TO) begin
          go(PH_RST);
          if (m_to < CMAX) m_to++;
        end
      end
      PH_STABLE: begin
        if (rq) go(PH_RST);
        else if (!ls) go(PH_WAIT);
        else if (d == SC) go(PH_RUN);
      end
      default: begin
        if (!ls) begin
          go(PH_RST);
          if (m_lol < CMAX) m_lol++;
        end else if (rq) go(PH_RST);
      end
    endcase
  endfunction

  task automatic check_outputs();
    chk("cyc_pll_rst", pll_rst, (m_ph == PH_RST));
    chk("cyc_ready", ready, (m_ph == PH_RUN));
    chk("cyc_vdc_reset", vdc_reset, (m_ph != PH_RUN));
    chk("cyc_lol_count", lol_count, m_lol);
    chk("cyc_timeout_count", timeout_count, m_to);
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    lk_h[n] = pll_locked;
    rq_h[n] = relock_req;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until(input int t);
    while (n < t) tick();
  endtask

  task automatic assert_reset();
    #2 reset_n = 1'b0;
    relock_req = 1'b0;
    #1;
    model_reset();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_vdc_reset", vdc_reset, 1);
    chk("rst_lol_count", lol_count, 0);
    chk("rst_timeout_count", timeout_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic scen1();
    pll_locked = 1'b0;
    run_until(3);
    chk("s1_pll_rst_c3", pll_rst, 1);
    run_until(4);
    chk("s1_pll_rst_c4", pll_rst, 0);
    run_until(9);
    pll_locked = 1'b1;
    run_until(19);
    chk("s1_ready_c19", ready, 0);
    run_until(20);
    chk("s1_ready_c20", ready, 1);
    chk("s1_vdc_reset_c20", vdc_reset, 0);
    chk("s1_lol", lol_count, 0);
    chk("s1_to", timeout_count, 0);
  endtask

  int hold;

  initial begin
    assert_reset();
    scen1();

    // lock never arrives: timeouts every 24 cycles, counter saturates at 3
    assert_reset();
    pll_locked = 1'b0;
    run_until(24);
    chk("s2_to_c24", timeout_count, 1);
    chk("s2_pll_rst_c24", pll_rst, 1);
    run_until(27);
    chk("s2_pll_rst_c27", pll_rst, 1);
    run_until(28);
    chk("s2_pll_rst_c28", pll_rst, 0);
    run_until(48);
    chk("s2_to_c48", timeout_count, 2);
    run_until(72);
    chk("s2_to_c72", timeout_count, 3);
    run_until(96);
    chk("s2_to_c96", timeout_count, 3);
    run_until(100);

    // one-cycle lock glitch after 5 locked cycles in STABLE
    assert_reset();
    pll_locked = 1'b1;
    run_until(8);
    pll_locked = 1'b0;
    run_until(9);
    pll_locked = 1'b1;
    run_until(13);
    chk("s3_ready_c13", ready, 0);
    run_until(19);
    chk("s3_ready_c19", ready, 0);
    run_until(20);
    chk("s3_ready_c20", ready, 1);
    chk("s3_lol", lol_count, 0);
    chk("s3_to", timeout_count, 0);

    // loss of lock in RUN
    run_until(30);
    pll_locked = 1'b0;
    run_until(32);
    chk("s4_ready_c32", ready, 1);
    run_until(33);
    chk("s4_ready_c33", ready, 0);
    chk("s4_vdc_reset_c33", vdc_reset, 1);
    chk("s4_pll_rst_c33", pll_rst, 1);
    chk("s4_lol_c33", lol_count, 1);
    pll_locked = 1'b1;
    run_until(45);
    chk("s4_ready_c45", ready, 0);
    run_until(46);
    chk("s4_ready_c46", ready, 1);

    // relock request alone, then together with loss of lock
    run_until(50);
    relock_req = 1'b1;
    run_until(51);
    relock_req = 1'b0;
    chk("s5_pll_rst_c51", pll_rst, 0);
    chk("s5_ready_c51", ready, 1);
    run_until(52);
    chk("s5_pll_rst_c52", pll_rst, 1);
    chk("s5_ready_c52", ready, 0);
    run_until(55);
    chk("s5_pll_rst_c55", pll_rst, 1);
    run_until(56);
    chk("s5_pll_rst_c56", pll_rst, 0);
    chk("s5_lol_c56", lol_count, 1);
    chk("s5_to_c56", timeout_count, 0);
    run_until(65);
    chk("s5_ready_c65", ready, 1);
    run_until(70);
    pll_locked = 1'b0;
    run_until(71);
    relock_req = 1'b1;
    run_until(72);
    relock_req = 1'b0;
    pll_locked = 1'b1;
    chk("s5_ready_c72", ready, 1);
    run_until(73);
    chk("s5_lol_c73", lol_count, 2);
    chk("s5_pll_rst_c73", pll_rst, 1);
    run_until(86);
    chk("s5_ready_c86", ready, 1);
    run_until(90);

    // asynchronous reset mid-RUN, then the power-up sequence again
    chk("s6_lol_before", lol_count, 2);
    assert_reset();
    scen1();

    for (int seg = 0; seg < 6; seg++) begin
      assert_reset();
      pll_locked = 1'b0;
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
        if (hold == 0) begin
          pll_locked = ($urandom_range(0, 99) < 60);
          hold = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 40);
        end
        hold--;
        relock_req = ($urandom_range(0, 63) == 0);
        tick();
      end
      relock_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
